// File: rtl/vector_tail_decoder.sv
// vector_tail_decoder
//   Collects thermometer-coded tail masks, one beat per register of a group,
//   and adds up the body elements (the contiguous ones from the LSB) of every
//   beat. When the group ends, the total vector length is returned over a
//   valid/ready handshake.
//
//   A group ends on an accepted beat with in_last=1, or on the accepted beat
//   that brings the beat count to MAX_BEATS. The result appears one cycle
//   after that beat is accepted. No beats are accepted while a result is
//   waiting, so there is at least one idle cycle between groups.
//
//   Optional feature: define VECTOR_TAIL_DECODER_CHECK_EN to build the
//   encoding checker that drives format_error. Without the macro,
//   format_error is tied to 0 and no checker logic is built.
//
// Ports
//   clock               rising-edge clock
//   reset               synchronous, active-high
//   in_valid/in_ready   beat handshake
//   encoded_vector_mask thermometer-coded tail mask for this beat
//   in_last             beat is the last one of its group
//   out_valid/out_ready result handshake
//   vector_length       total body elements in the group
//   beat_count          number of beats consumed by the group
//   format_error        the group broke the encoding rules (checker build only)
//
// State | meaning
// ------+-----------------------------------------------------------
// ACCUM | accepting beats and adding them up (in_ready=1)
// HOLD  | group result presented, waiting for out_ready (out_valid=1)

module vector_tail_decoder #(
  parameter  int VECTOR_MASK_LENGTH = 8,
  parameter  int MAX_BEATS          = 8,
  localparam int COUNT_WIDTH        = $clog2(VECTOR_MASK_LENGTH*MAX_BEATS+1),
  localparam int BEAT_WIDTH         = $clog2(MAX_BEATS+1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VECTOR_MASK_LENGTH-1:0] encoded_vector_mask,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COUNT_WIDTH-1:0]        vector_length,
  output logic [BEAT_WIDTH-1:0]         beat_count,
  output logic                          format_error
);

  localparam int ONES_WIDTH = $clog2(VECTOR_MASK_LENGTH+1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                  state;
  logic [COUNT_WIDTH-1:0]  acc;
  logic [COUNT_WIDTH-1:0]  acc_next;
  logic [BEAT_WIDTH-1:0]   beats;
  logic [BEAT_WIDTH-1:0]   beats_next;
  logic [ONES_WIDTH-1:0]   beat_ones;
  logic                    accept;
  logic                    max_hit;
  logic                    group_end;

  // The beat's count is the index of its lowest zero, or the full width when
  // every bit is set. Bits above the lowest zero are ignored here.
  function automatic logic [ONES_WIDTH-1:0] trailing_ones(
    input logic [VECTOR_MASK_LENGTH-1:0] mask
  );
    logic [ONES_WIDTH-1:0] n;
    logic                  stop;
    n    = '0;
    stop = 1'b0;
    for (int i = 0; i < VECTOR_MASK_LENGTH; i++) begin
      if (!stop) begin
        if (mask[i]) n = n + ONES_WIDTH'(1);
        else         stop = 1'b1;
      end
    end
    return n;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  always_comb begin
    beat_ones  = trailing_ones(encoded_vector_mask);
    acc_next   = acc + COUNT_WIDTH'(beat_ones);
    beats_next = beats + BEAT_WIDTH'(1);
    max_hit    = (beats_next == BEAT_WIDTH'(MAX_BEATS));
    group_end  = accept & (in_last | max_hit);
  end

  // The accumulators are cleared as soon as the result has been captured
  // into the output registers. Because nothing is accepted in HOLD, that
  // is the same as clearing them when the result is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ACCUM;
      acc           <= '0;
      beats         <= '0;
      vector_length <= '0;
      beat_count    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (group_end) begin
              state         <= HOLD;
              vector_length <= acc_next;
              beat_count    <= beats_next;
              acc           <= '0;
              beats         <= '0;
            end else begin
              acc   <= acc_next;
              beats <= beats_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifdef VECTOR_TAIL_DECODER_CHECK_EN
  logic tail_seen;
  logic err_acc;
  logic err_q;
  logic beat_bad;
  logic err_next;

  // A beat is bad if it has a one above its lowest zero, if it has body
  // elements after an earlier beat already had a tail, or if it closes the
  // group only because MAX_BEATS was reached and in_last was not set.
  always_comb begin
    beat_bad = ((encoded_vector_mask >> beat_ones) != '0)
             | (tail_seen & (beat_ones != '0))
             | (max_hit & ~in_last);
    err_next = err_acc | beat_bad;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tail_seen <= 1'b0;
      err_acc   <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      if (group_end) begin
        err_q     <= err_next;
        tail_seen <= 1'b0;
        err_acc   <= 1'b0;
      end else begin
        tail_seen <= tail_seen | (beat_ones < ONES_WIDTH'(VECTOR_MASK_LENGTH));
        err_acc   <= err_next;
      end
    end
  end

  assign format_error = err_q;
`else
  assign format_error = 1'b0;
`endif

endmodule

// File: tb/tb_vector_tail_decoder.sv
module tb_vector_tail_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] encoded_vector_mask;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] vector_length;
  logic [3:0] beat_count;
  logic       format_error;

  int checks = 0;
  int errors = 0;

  bit [7:0] grp[$];

`ifdef VECTOR_TAIL_DECODER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  vector_tail_decoder dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .encoded_vector_mask (encoded_vector_mask),
    .in_last             (in_last),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .vector_length       (vector_length),
    .beat_count          (beat_count),
    .format_error        (format_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: a group is a list of masks. Counts come from walking
  // each mask bit by bit; the checker rules are evaluated directly.
  task automatic model(input bit use_last, output int vl, output int bc, output int err);
    int  c;
    bit  tail;
    vl   = 0;
    err  = 0;
    tail = 0;
    bc   = grp.size();
    foreach (grp[i]) begin
      c = 0;
      while (c < 8 && grp[i][c]) c++;
      vl += c;
      if (int'(grp[i]) != ((1 << c) - 1)) err = 1;
      if (tail && c > 0) err = 1;
      if (c < 8) tail = 1;
    end
    if (!use_last && bc == 8) err = 1;
    if (!CHECK_EN) err = 0;
  endtask

  task automatic send_beat(input bit [7:0] m, input bit last);
    in_valid            = 1'b1;
    encoded_vector_mask = m;
    in_last             = last;
    check("in_ready_accum", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends grp, checks the result, applies `stall` cycles of backpressure
  // while offering a stray beat, then completes the handshake.
  task automatic run_group(input string tag, input bit use_last, input int stall);
    int vl, bc, err;
    model(use_last, vl, bc, err);
    foreach (grp[i]) send_beat(grp[i], use_last && (i == grp.size() - 1));
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_vl"}, vector_length, vl);
    check({tag, "_bc"}, beat_count, bc);
    check({tag, "_err"}, format_error, err);
    for (int k = 0; k < stall; k++) begin
      in_valid            = 1'b1;
      encoded_vector_mask = 8'($urandom);
      in_last             = 1'b1;
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_vl"}, vector_length, vl);
      check({tag, "_hold_bc"}, beat_count, bc);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, out_valid, 0);
    check({tag, "_release_ready"}, in_ready, 1);
    check({tag, "_keep_vl"}, vector_length, vl);
  endtask

  initial begin
    int n, c;
    bit use_last;
    reset               = 1'b1;
    in_valid            = 1'b1;
    in_last             = 1'b0;
    encoded_vector_mask = 8'hFF;
    out_ready           = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_vl", vector_length, 0);
    check("rst_bc", beat_count, 0);
    check("rst_err", format_error, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_out_valid", out_valid, 0);

    grp = '{8'h1F};
    run_group("single", 1, 0);
    grp = '{8'hFF, 8'hFF, 8'h07};
    run_group("three", 1, 3);
    grp = '{8'h5F};
    run_group("malformed", 1, 0);
    grp = '{8'h03, 8'h01};
    run_group("after_tail", 1, 1);
    grp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_group("max_no_last", 0, 0);
    run_group("max_with_last", 1, 0);

    // Reset mid-group discards the partial sum.
    send_beat(8'hFF, 0);
    send_beat(8'hFF, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    grp = '{8'h01};
    run_group("after_midrst", 1, 0);

    // Reset in HOLD drops the pending result; reset beats a handshake.
    grp = '{8'h0F};
    foreach (grp[i]) send_beat(grp[i], 1);
    check("hold_before_rst", out_valid, 1);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    check("holdrst_out_valid", out_valid, 0);
    check("holdrst_in_ready", in_ready, 1);
    check("holdrst_vl", vector_length, 0);

    for (int g = 0; g < 25; g++) begin
      n        = $urandom_range(1, 8);
      use_last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      grp.delete();
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          grp.push_back(8'($urandom));
        end else begin
          c = $urandom_range(0, 8);
          grp.push_back(8'((1 << c) - 1));
        end
      end
      run_group("random", use_last, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
